borrow_skip_subtractor_seq: RTL and testbench
=============================================

BORROW_SKIP_SUBTRACTOR_SEQ -- requirements
Module: borrow_skip_subtractor_seq

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: operand/result width; legal values are multiples of 4, minimum 8.
REQ-002 SHALL use G = BIT_WIDTH/4 groups of 4 bits; group 0 is bits [3:0].
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 valid_i  input  1  request valid.
REQ-007 ready_o  output  1  block can accept a request.
REQ-008 operand1_i  input  BIT_WIDTH  minuend A.
REQ-009 operand2_i  input  BIT_WIDTH  subtrahend B.
REQ-010 borrow_i  input  1  borrow-in.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  consumer accepts the result.
REQ-013 diff_o  output  BIT_WIDTH  A - B - borrow_i, modulo 2^BIT_WIDTH.
REQ-014 borrow_o  output  1  borrow-out: 1 iff A < B + borrow_i, unsigned.
REQ-015 overflow_o  output  1  signed (two's-complement) overflow.
REQ-016 zero_o  output  1  diff_o == 0.

Function
REQ-017 SHALL implement states IDLE, CALC and DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-018 In IDLE, a cycle with valid_i && ready_o is an acceptance edge: the block registers A, B and borrow_i, clears the group index to 0 and the running borrow to borrow_i, and enters CALC.
REQ-019 On each edge in CALC, the block performs one step on current group g:
- nibble diff = A[g] - B[g] - borrow, modulo 16;
- borrow-out set when A[g] < B[g] + borrow.
REQ-020 Skip rule: if g+1 < G and A[g+1] == B[g+1], the same step also resolves group g+1:
- diff nibble = {4{borrow-out of g}};
- borrow passes through unchanged;
- index advances by 2.
- Otherwise the index advances by 1.
REQ-021 Only one group is skipped per step. The current group g is always computed normally, even when its nibbles are equal.
REQ-022 The step that resolves group G-1 SHALL:
- register diff_o and borrow_o;
- register overflow_o = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
- register zero_o;
- enter DONE.
REQ-023 With S steps, valid_o rises immediately after edge E0+S, where E0 is the acceptance edge. S ranges from ceil(G/2) to G.
REQ-024 In DONE, all outputs SHALL hold stable while ready_i = 0. On the edge with ready_i = 1 the block enters IDLE; ready_o = 1 from the next cycle. There is no same-cycle re-accept.
REQ-025 valid_i and operand changes outside the acceptance edge SHALL be ignored.
REQ-026 BIT_WIDTH not a multiple of 4, or less than 8, SHALL be rejected at elaboration.

Reset
REQ-027 rst_ni = 0 SHALL immediately force:
- state IDLE;
- valid_o = 0, diff_o = 0, borrow_o = 0, overflow_o = 0, zero_o = 0;
- internal registers cleared.
- ready_o = 1 while in reset.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation with no result delivered. After release, the block accepts on the first valid_i.

Verification (BIT_WIDTH = 32, G = 8)
REQ-029 0x00000005 - 0x00000003, borrow_i = 0 -> diff_o 0x00000002, borrow_o 0, overflow_o 0, zero_o 0, S = 4.
REQ-030 0x00000000 - 0x00000001, borrow_i = 0 -> diff_o 0xFFFFFFFF, borrow_o 1, overflow_o 0, S = 4. 0x80000000 - 0x00000001 -> diff_o 0x7FFFFFFF, borrow_o 0, overflow_o 1, S = 5.
REQ-031 0x12345678 - 0x87654321, borrow_i = 0 (no equal nibbles) -> diff_o 0x8ACF1357, borrow_o 1, overflow_o 1, S = 8.
REQ-032 0xA5A5A5A5 - 0xA5A5A5A5: borrow_i = 0 -> diff_o 0, zero_o 1, S = 4; borrow_i = 1 -> diff_o 0xFFFFFFFF, borrow_o 1, zero_o 0.
REQ-033 Backpressure and handshake: hold ready_i = 0 for 3 cycles in DONE -> outputs stable, ready_o 0. Assert ready_i -> valid_o 0 and ready_o 1 next cycle. valid_i held high in CALC does not restart the operation.
REQ-034 Reset mid-operation: drop rst_ni on the 2nd CALC step -> valid_o 0, ready_o 1, outputs 0. After release, a new 5 - 3 request returns 2 with S = 4.

Source files
------------

// File: rtl/borrow_skip_subtractor_seq.sv
// borrow_skip_subtractor_seq: multi-cycle nibble-serial subtractor; each step also
// resolves the following group when its nibbles are equal, since only the borrow passes through it.
module borrow_skip_subtractor_seq #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [BIT_WIDTH-1:0] operand1_i,
  input  logic [BIT_WIDTH-1:0] operand2_i,
  input  logic                 borrow_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [BIT_WIDTH-1:0] diff_o,
  output logic                 borrow_o,
  output logic                 overflow_o,
  output logic                 zero_o
);
  localparam int G = BIT_WIDTH / 4;
  localparam int IW = $clog2(G) + 1;
  localparam logic [IW-1:0] GC = IW'(G);
  if (BIT_WIDTH % 4 != 0 || BIT_WIDTH < 8) begin : g_bad_width
    $error("BIT_WIDTH must be a multiple of 4 and at least 8");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [BIT_WIDTH-1:0] a, b, acc, acc_nx, nib;
  logic [IW-1:0] idx, idx_nx;
  logic [7:0] a_w, b_w;
  logic [4:0] sub;
  logic brw, bo, skip, last;
  // Window of the current group and the one above it, so the skip test needs no extra mux.
  always_comb begin
    a_w = 8'(a >> {idx, 2'b00});
    b_w = 8'(b >> {idx, 2'b00});
    sub = {1'b0, a_w[3:0]} - {1'b0, b_w[3:0]} - {4'b0, brw};
    bo = sub[4];
    skip = (idx != GC - 1'b1) && (a_w[7:4] == b_w[7:4]);
    nib = BIT_WIDTH'({skip ? {4{bo}} : 4'b0, sub[3:0]});
    acc_nx = acc | (nib << {idx, 2'b00});
    idx_nx = idx + (skip ? IW'(2) : IW'(1));
    last = idx_nx >= GC;
  end
  always_comb begin
    ready_o = state == IDLE;
    valid_o = state == DONE;
    state_nx = state == IDLE ? (valid_i ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               (ready_i ? IDLE : DONE);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a <= '0;
      b <= '0;
      acc <= '0;
      idx <= '0;
      brw <= 1'b0;
      diff_o <= '0;
      borrow_o <= 1'b0;
      overflow_o <= 1'b0;
      zero_o <= 1'b0;
    end else if (state == IDLE && valid_i) begin
      a <= operand1_i;
      b <= operand2_i;
      brw <= borrow_i;
      acc <= '0;
      idx <= '0;
    end else if (state == CALC) begin
      acc <= acc_nx;
      idx <= idx_nx;
      brw <= bo;
      if (last) begin
        diff_o <= acc_nx;
        borrow_o <= bo;
        overflow_o <= (a[BIT_WIDTH-1] != b[BIT_WIDTH-1]) && (acc_nx[BIT_WIDTH-1] != a[BIT_WIDTH-1]);
        zero_o <= acc_nx == '0;
      end
    end
  end
endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// tb_borrow_skip_subtractor_seq: directed and random subtractions against an arithmetic reference model.
module tb_borrow_skip_subtractor_seq;
  localparam int W = 32;
  localparam int G = W / 4;
  logic clk = 1'b0;
  logic rst_n, valid_in, ready_out, borrow_in, valid_out, ready_in, borrow_out, overflow, zero;
  logic [W-1:0] op1, op2, diff;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  borrow_skip_subtractor_seq #(.BIT_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ready_out),
    .operand1_i(op1), .operand2_i(op2), .borrow_i(borrow_in), .valid_o(valid_out),
    .ready_i(ready_in), .diff_o(diff), .borrow_o(borrow_out), .overflow_o(overflow), .zero_o(zero)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int model_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    int s = 0;
    while (g < G) begin
      s++;
      if (g + 1 < G && a[4*(g+1) +: 4] == b[4*(g+1) +: 4]) g += 2;
      else g += 1;
    end
    return s;
  endfunction
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n = 0;
    while (!ready_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) check("ready_timeout", 0, 1);
    op1 = a;
    op2 = b;
    borrow_in = bin;
    valid_in = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input int hold, input bit noise);
    logic [W:0] full;
    logic [W-1:0] ed;
    logic eb, ev, ez;
    int s, n;
    full = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    ed = full[W-1:0];
    eb = {1'b0, a} < {1'b0, b} + (W+1)'(bin);
    ev = (a[W-1] != b[W-1]) && (ed[W-1] != a[W-1]);
    ez = ed == '0;
    s = model_steps(a, b);
    start_op(a, b, bin);
    valid_in = noise;
    n = 0;
    while (!valid_out && n < 2 * G + 4) begin
      check("busy_ready", ready_out, 0);
      if (noise) begin
        op1 = $urandom;
        op2 = $urandom;
        borrow_in = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check("steps", n, s);
    check("valid", valid_out, 1);
    check("diff", diff, ed);
    check("borrow", borrow_out, eb);
    check("overflow", overflow, ev);
    check("zero", zero, ez);
    ready_in = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", valid_out, 1);
      check("hold_ready", ready_out, 0);
      check("hold_diff", {borrow_out, overflow, zero, diff}, {eb, ev, ez, ed});
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check("release_valid", valid_out, 0);
    check("release_ready", ready_out, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [W-1:0] a, b, m;
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    borrow_in = 1'b0;
    op1 = '0;
    op2 = '0;
    #1;
    check("rst_outputs", {valid_out, borrow_out, overflow, zero, diff}, '0);
    check("rst_ready", ready_out, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'h5, 32'h3, 1'b0, 0, 1'b0);
    run_op(32'h0, 32'h1, 1'b0, 1, 1'b0);
    run_op(32'h80000000, 32'h1, 1'b0, 0, 1'b1);
    run_op(32'h12345678, 32'h87654321, 1'b0, 3, 1'b1);
    run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0, 1'b0);
    run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 2, 1'b0);
    run_op(32'hFFFFFFFF, 32'h0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      m = $urandom;
      for (int j = 0; j < G; j++) if (m[j]) b[4*j +: 4] = a[4*j +: 4];
      run_op(a, b, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    start_op(32'h12345678, 32'h87654321, 1'b0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {valid_out, borrow_out, overflow, zero, diff}, '0);
    check("abort_ready", ready_out, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'h5, 32'h3, 1'b0, 1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
